// File: rtl/nes_pad_responder_if.sv
// Serial pad link: console latch/clock toward the pad, data back.
// master = console side, slave = pad side.
interface nes_pad_responder_if;
  logic nes_latch;
  logic nes_clk;
  logic data_out;

  modport master (
    output nes_latch,
    output nes_clk,
    input  data_out
  );

  modport slave (
    input  nes_latch,
    input  nes_clk,
    output data_out
  );
endinterface

// File: rtl/nes_pad_responder.sv
// NES pad emulator: latch samples buttons, console clock shifts them out.
// Optional auto-fire for A/B under macro NES_PAD_TURBO_EN.
module nes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TURBO_FRAMES   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  nes_pad_responder_if.slave    pad,
  input  logic [7:0]            buttons,
  input  logic                  turbo_a,
  input  logic                  turbo_b,
  output logic                  busy,
  output logic                  frame_done,
  output logic [3:0]            bit_index
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   latch_q;
  logic                   clk_q;
  logic                   latch_s;
  logic                   clk_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   clk_rise;
  logic                   any_edge;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [7:0]    sr;
  logic [7:0]    sr_n;
  logic [3:0]    idx;
  logic [3:0]    idx_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          dout;
  logic          dout_n;
  logic          done_n;
  logic [7:0]    load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      latch_q    <= 1'b0;
      clk_q      <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad.nes_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], pad.nes_clk};
      latch_q    <= latch_s;
      clk_q      <= clk_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_q;
  assign latch_fall = ~latch_s & latch_q;
  assign clk_rise   = clk_s & ~clk_q;
  assign any_edge   = (latch_s ^ latch_q) | (clk_s ^ clk_q);

`ifdef NES_PAD_TURBO_EN
  localparam int FW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(TURBO_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (latch_fall) begin
      if (frame_cnt == FRM_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Phase 0 fires, so the first frames after reset report the press.
  always_comb begin
    load_val = buttons;
    if (turbo_a) load_val[0] = buttons[0] & ~phase;
    if (turbo_b) load_val[1] = buttons[1] & ~phase;
  end
`else
  logic unused_turbo;
  assign unused_turbo = turbo_a ^ turbo_b;
  assign load_val     = buttons;
`endif

  always_comb begin
    state_n = state;
    sr_n    = sr;
    idx_n   = idx;
    cnt_n   = cnt;
    dout_n  = dout;
    done_n  = 1'b0;
    if (latch_rise) begin
      state_n = LOAD;
      sr_n    = load_val;
      idx_n   = 4'd0;
      cnt_n   = '0;
      dout_n  = ~load_val[0];
    end else begin
      unique case (state)
        IDLE: begin
          dout_n = 1'b1;
          idx_n  = 4'd0;
          cnt_n  = '0;
        end
        LOAD: begin
          sr_n   = load_val;
          dout_n = ~load_val[0];
          idx_n  = 4'd0;
          cnt_n  = '0;
          if (latch_fall) state_n = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            sr_n  = {1'b1, sr[7:1]};
            idx_n = idx + 4'd1;
            cnt_n = '0;
            if (idx == 4'd7) begin
              state_n = DONE;
              done_n  = 1'b1;
              dout_n  = 1'b0;
            end else begin
              dout_n = ~sr[1];
            end
          end else if (any_edge) begin
            cnt_n = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = IDLE;
            dout_n  = 1'b1;
            idx_n   = 4'd0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DONE: begin
          dout_n = 1'b0;
          if (any_edge) begin
            cnt_n = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = IDLE;
            dout_n  = 1'b1;
            idx_n   = 4'd0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          dout_n  = 1'b1;
          idx_n   = 4'd0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= 8'h00;
      idx        <= 4'd0;
      cnt        <= '0;
      dout       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      busy       <= (state_n == LOAD) || (state_n == SHIFT);
      frame_done <= done_n;
    end
  end

  assign pad.data_out = dout;
  assign bit_index    = idx;

endmodule
